// File: rtl/uart_tx_frame.sv
// uart_tx_frame: start bit, 8 data bits LSB-first, optional even parity (UART_TX_PARITY_EN), STOP_BITS stop bits.
// txd is registered and moves together with state; a byte accepted at an edge drives its start bit right after it.
module uart_tx_frame #(
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  output logic       txd,
  output logic       busy,
  output logic       tx_done
);

  localparam int            BW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP
`ifdef UART_TX_PARITY_EN
    , PARITY
`endif
  } state_t;

  state_t        state, state_n;
  logic [BW-1:0] baud_cnt, baud_n;
  logic [2:0]    bit_idx, bit_n;
  logic          stop_idx, stop_n;
  logic [7:0]    shift_reg, shift_n;
  logic          txd_q, txd_n;
  logic          rdy_en;
`ifdef UART_TX_PARITY_EN
  logic          parity_q, parity_n;
`endif

  logic baud_wrap;
  logic accept;

  assign baud_wrap  = (baud_cnt == BAUD_LAST);
  assign tx_done    = (state == STOP) && baud_wrap && (stop_idx == STOP_LAST);
  // rdy_en keeps data_ready low until the first edge after reset release
  assign data_ready = ((state == IDLE) && rdy_en) || tx_done;
  assign accept     = data_valid && data_ready;
  assign busy       = (state != IDLE);
  assign txd        = txd_q;

  always_comb begin
    state_n  = state;
    baud_n   = baud_cnt;
    bit_n    = bit_idx;
    stop_n   = stop_idx;
    shift_n  = shift_reg;
    txd_n    = txd_q;
`ifdef UART_TX_PARITY_EN
    parity_n = parity_q;
`endif

    if (state != IDLE) begin
      baud_n = baud_wrap ? '0 : baud_cnt + BW'(1);
    end

    case (state)
      IDLE: begin
        txd_n = 1'b1;
      end
      START: begin
        if (baud_wrap) begin
          state_n = DATA;
          bit_n   = '0;
          txd_n   = shift_reg[0];
        end
      end
      DATA: begin
        if (baud_wrap) begin
          shift_n = {1'b0, shift_reg[7:1]};
          if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_n = PARITY;
            txd_n   = parity_q;
`else
            state_n = STOP;
            stop_n  = 1'b0;
            txd_n   = 1'b1;
`endif
          end else begin
            bit_n = bit_idx + 3'd1;
            txd_n = shift_reg[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (baud_wrap) begin
          state_n = STOP;
          stop_n  = 1'b0;
          txd_n   = 1'b1;
        end
      end
`endif
      STOP: begin
        txd_n = 1'b1;
        if (baud_wrap) begin
          if (tx_done) begin
            state_n = IDLE;
          end else begin
            stop_n = stop_idx + 1'b1;
          end
        end
      end
      default: begin
        state_n = IDLE;
        txd_n   = 1'b1;
      end
    endcase

    // Acceptance is only possible in IDLE or on the tx_done cycle, so it
    // overrides whatever the case above chose and gives a gapless restart.
    if (accept) begin
      state_n  = START;
      baud_n   = '0;
      shift_n  = data_in;
      txd_n    = 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_n = ^data_in;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      stop_idx  <= 1'b0;
      shift_reg <= '0;
      txd_q     <= 1'b1;
      rdy_en    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      baud_cnt  <= baud_n;
      bit_idx   <= bit_n;
      stop_idx  <= stop_n;
      shift_reg <= shift_n;
      txd_q     <= txd_n;
      rdy_en    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_n;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: DUT a has STOP_BITS=1, DUT b has STOP_BITS=2, both CLKS_PER_BIT=4.
module tb_uart_tx_frame;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  typedef struct packed {
    logic [7:0] d;
    logic       par;
  } vec_t;

  logic       clk;
  logic       rst_a, rst_b;
  logic       sel;
  logic [7:0] din;
  logic       vld;
  logic       vld_a, vld_b;
  logic       rdy_a, rdy_b, txd_a, txd_b, busy_a, busy_b, done_a, done_b;
  logic       rdy_s, txd_s, busy_s, done_s;

  int total = 0;
  int bad   = 0;
  int fl_cur;

  logic [127:0] tx_tr, bz_tr, dn_tr, rd_tr;
  logic [127:0] ex_tx, ex_bz, ex_dn, ex_rd;
  vec_t         vecs[6];

  assign vld_a  = vld && !sel;
  assign vld_b  = vld && sel;
  assign rdy_s  = sel ? rdy_b  : rdy_a;
  assign txd_s  = sel ? txd_b  : txd_a;
  assign busy_s = sel ? busy_b : busy_a;
  assign done_s = sel ? done_b : done_a;

  uart_tx_frame #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) u_a (
    .clk(clk), .rst(rst_a), .data_in(din), .data_valid(vld_a),
    .data_ready(rdy_a), .txd(txd_a), .busy(busy_a), .tx_done(done_a)
  );

  uart_tx_frame #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) u_b (
    .clk(clk), .rst(rst_b), .data_in(din), .data_valid(vld_b),
    .data_ready(rdy_b), .txd(txd_b), .busy(busy_b), .tx_done(done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] decode(input int start);
    logic [7:0] r;
    for (int b = 0; b < 8; b++) r[b] = tx_tr[start - 1 + (b + 1) * CPB + 1];
    return r;
  endfunction

  task automatic exp_idle(input int n);
    for (int k = 0; k < 128; k++) begin
      ex_tx[k] = (k < n);
      ex_bz[k] = 1'b0;
      ex_dn[k] = 1'b0;
    end
  endtask

  task automatic exp_frame(input int start, input logic [7:0] d, input logic p, input int stops);
    int   nsl;
    int   idx;
    logic b;
    nsl = 1 + 8 + PB + stops;
    for (int s = 0; s < nsl; s++) begin
      if (s == 0)                b = 1'b0;
      else if (s <= 8)           b = d[s-1];
      else if (PB == 1 && s == 9) b = p;
      else                       b = 1'b1;
      for (int j = 0; j < CPB; j++) begin
        idx        = start - 1 + s * CPB + j;
        ex_tx[idx] = b;
        ex_bz[idx] = 1'b1;
        ex_dn[idx] = (s == nsl - 1) && (j == CPB - 1);
      end
    end
  endtask

  // Ready is expected when the line is idle (not busy) or on a tx_done cycle.
  task automatic exp_ready(input int n);
    for (int k = 0; k < 128; k++) ex_rd[k] = (k < n) && (!ex_bz[k] || ex_dn[k]);
  endtask

  // mode 0: drop valid; 1: keep valid, switch to 0x3C, drop on 2nd tx_done; 2: random inputs while busy
  task automatic capture(input int n, input int mode);
    tx_tr = '0; bz_tr = '0; dn_tr = '0; rd_tr = '0;
    for (int k = 1; k <= n; k++) begin
      tx_tr[k-1] = txd_s;
      bz_tr[k-1] = busy_s;
      dn_tr[k-1] = done_s;
      rd_tr[k-1] = rdy_s;
      case (mode)
        0: vld = 1'b0;
        1: begin
          if (k == 1) din = 8'h3C;
          if (k == 2 * fl_cur) vld = 1'b0;
        end
        default: begin
          if (k < fl_cur) begin
            din = 8'($urandom);
            vld = 1'($urandom_range(0, 1));
          end else begin
            vld = 1'b0;
          end
        end
      endcase
      @(negedge clk);
    end
  endtask

  task automatic wait_ready(input string tag);
    int t;
    t = 0;
    while (!rdy_s && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_ready_wait"}, rdy_s, 1'b1);
  endtask

  task automatic send_frame(input logic [7:0] d, input int mode, input int n, input string tag);
    wait_ready(tag);
    chk({tag, "_line_idle"}, txd_s, 1'b1);
    din = d;
    vld = 1'b1;
    @(negedge clk);
    capture(n, mode);
  endtask

  task automatic check_traces(input string tag);
    chk({tag, "_txd"},  tx_tr, ex_tx);
    chk({tag, "_busy"}, bz_tr, ex_bz);
    chk({tag, "_done"}, dn_tr, ex_dn);
    chk({tag, "_rdy"},  rd_tr, ex_rd);
  endtask

  task automatic run_vec(input logic [7:0] d, input logic p, input int mode, input string tag);
    int stops;
    int n;
    stops  = sel ? 2 : 1;
    fl_cur = (9 + PB + stops) * CPB;
    n      = fl_cur + 8;
    exp_idle(n);
    exp_frame(1, d, p, stops);
    exp_ready(n);
    send_frame(d, mode, n, tag);
    check_traces(tag);
    chk({tag, "_byte"}, decode(1), d);
    if (PB == 1) chk({tag, "_parity"}, tx_tr[9 * CPB + 1], p);
  endtask

  initial begin
    logic seen;
    vecs[0] = '{d: 8'h55, par: 1'b0};
    vecs[1] = '{d: 8'h07, par: 1'b1};
    vecs[2] = '{d: 8'h03, par: 1'b0};
    vecs[3] = '{d: 8'h00, par: 1'b0};
    vecs[4] = '{d: 8'h80, par: 1'b1};
    vecs[5] = '{d: 8'hC3, par: 1'b0};

    rst_a = 1'b0; rst_b = 1'b0; sel = 1'b0; din = 8'h00; vld = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_txd_a",  txd_a,  1'b1);
    chk("rst_rdy_a",  rdy_a,  1'b0);
    chk("rst_busy_a", busy_a, 1'b0);
    chk("rst_done_a", done_a, 1'b0);
    chk("rst_txd_b",  txd_b,  1'b1);
    chk("rst_rdy_b",  rdy_b,  1'b0);
    rst_a = 1'b1; rst_b = 1'b1;
    #1;
    chk("rel_rdy_before_edge", rdy_a, 1'b0);
    @(negedge clk);
    chk("rel_rdy_after_edge_a", rdy_a, 1'b1);
    chk("rel_rdy_after_edge_b", rdy_b, 1'b1);

    for (int i = 0; i < 6; i++) run_vec(vecs[i].d, vecs[i].par, 0, $sformatf("vec%0d", i));

    // back-to-back 0xA5 then 0x3C with valid held high
    fl_cur = (9 + PB + 1) * CPB;
    exp_idle(2 * fl_cur + 6);
    exp_frame(1, 8'hA5, 1'b0, 1);
    exp_frame(fl_cur + 1, 8'h3C, 1'b0, 1);
    exp_ready(2 * fl_cur + 6);
    send_frame(8'hA5, 1, 2 * fl_cur + 6, "b2b");
    check_traces("b2b");
    chk("b2b_byte0", decode(1), 8'hA5);
    chk("b2b_byte1", decode(fl_cur + 1), 8'h3C);
    chk("b2b_no_gap", tx_tr[fl_cur], 1'b0);

    // inputs toggled while busy must not disturb the frame or start another
    run_vec(8'h6B, 1'b1, 2, "ignore");

    // asynchronous reset during data bit 3 of 0xF0 (bit 3 is 0)
    wait_ready("midrst");
    din = 8'hF0; vld = 1'b1;
    @(negedge clk);
    vld = 1'b0;
    repeat (17) @(negedge clk);
    chk("midrst_bit3_low", txd_a, 1'b0);
    rst_a = 1'b0;
    #1;
    chk("midrst_txd",  txd_a,  1'b1);
    chk("midrst_busy", busy_a, 1'b0);
    chk("midrst_done", done_a, 1'b0);
    chk("midrst_rdy",  rdy_a,  1'b0);
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done_a || !txd_a) seen = 1'b1;
    end
    rst_a = 1'b1;
    #1;
    chk("midrst_rel_rdy0", rdy_a, 1'b0);
    for (int c = 0; c < 2 * (9 + PB + 1) * CPB; c++) begin
      @(negedge clk);
      if (done_a || !txd_a || busy_a) seen = 1'b1;
    end
    chk("midrst_quiet", seen, 1'b0);
    run_vec(8'h81, 1'b0, 0, "after_rst");

    // two stop bits
    sel = 1'b1;
    run_vec(8'hFF, 1'b0, 0, "stop2_ff");
    run_vec(8'h5A, 1'b0, 0, "stop2_5a");
    sel = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
